// File: rtl/pipelined_addsub_pkg.sv
// Shared flag-bus bit ordering, common to the ALU, the branch unit and this adder.
package pipelined_addsub_pkg;
  localparam int FLAG_W  = 4;
  localparam int FLAG_CF = 0;
  localparam int FLAG_OF = 1;
  localparam int FLAG_ZF = 2;
  localparam int FLAG_SF = 3;
endpackage

// File: rtl/pipelined_addsub_chunk.sv
// Combinational CHUNK-bit adder slice; one instance per pipeline stage.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] sum_s;

  assign sum_s     = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign {cout, s} = sum_s;
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK of the carry chain per stage, global stall,
// flags computed alongside the final chunk and registered with the sum.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cf,
  output logic             of,
  output logic             zf,
  output logic             sf
);
  localparam int CHUNK = WIDTH / STAGES;

  // Stage k register: operands (B already conditioned), partial sum, chunk carry.
  logic [STAGES-1:0] valid_r;
  logic [WIDTH-1:0]  a_r     [STAGES];
  logic [WIDTH-1:0]  b_r     [STAGES];
  logic [WIDTH-1:0]  s_r     [STAGES];
  logic              carry_r [STAGES];
  logic [FLAG_W-1:0] flags_r;

  logic [WIDTH-1:0]  a_in_s   [STAGES];
  logic [WIDTH-1:0]  b_in_s   [STAGES];
  logic [WIDTH-1:0]  s_in_s   [STAGES];
  logic [WIDTH-1:0]  s_nxt_s  [STAGES];
  logic [CHUNK-1:0]  chunk_s  [STAGES];
  logic              cin_s    [STAGES];
  logic              cout_s   [STAGES];
  logic              vin_s    [STAGES];
  logic [FLAG_W-1:0] flags_nxt_s;
  logic              adv_s;

  function automatic logic [WIDTH-1:0] splice_chunk(input logic [WIDTH-1:0] word,
                                                    input logic [CHUNK-1:0] part,
                                                    input int               idx);
    logic [WIDTH-1:0] res;
    res = word;
    res[idx*CHUNK +: CHUNK] = part;
    return res;
  endfunction

  assign adv_s    = out_ready | ~valid_r[STAGES-1];
  assign in_ready = adv_s;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_entry
        // sub is applied here once; later stages only ever see the effective B.
        assign a_in_s[k] = a;
        assign b_in_s[k] = b ^ {WIDTH{sub}};
        assign s_in_s[k] = {WIDTH{1'b0}};
        assign cin_s[k]  = ci;
        assign vin_s[k]  = in_valid;
      end else begin : g_follow
        assign a_in_s[k] = a_r[k-1];
        assign b_in_s[k] = b_r[k-1];
        assign s_in_s[k] = s_r[k-1];
        assign cin_s[k]  = carry_r[k-1];
        assign vin_s[k]  = valid_r[k-1];
      end

      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_in_s[k][k*CHUNK +: CHUNK]),
        .b    (b_in_s[k][k*CHUNK +: CHUNK]),
        .cin  (cin_s[k]),
        .s    (chunk_s[k]),
        .cout (cout_s[k])
      );

      assign s_nxt_s[k] = splice_chunk(s_in_s[k], chunk_s[k], k);
    end
  endgenerate

  // Flags for the beat entering the last register, so they line up with its sum.
  always_comb begin
    flags_nxt_s          = {FLAG_W{1'b0}};
    flags_nxt_s[FLAG_CF] = cout_s[STAGES-1];
    flags_nxt_s[FLAG_OF] = ~(a_in_s[STAGES-1][WIDTH-1] ^ b_in_s[STAGES-1][WIDTH-1])
                         & (a_in_s[STAGES-1][WIDTH-1] ^ s_nxt_s[STAGES-1][WIDTH-1]);
    flags_nxt_s[FLAG_ZF] = (s_nxt_s[STAGES-1] == {WIDTH{1'b0}});
    flags_nxt_s[FLAG_SF] = s_nxt_s[STAGES-1][WIDTH-1];
  end

  // Pipeline registers: every stage shifts on adv, otherwise the whole pipe holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {STAGES{1'b0}};
      flags_r <= {FLAG_W{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        a_r[i]     <= {WIDTH{1'b0}};
        b_r[i]     <= {WIDTH{1'b0}};
        s_r[i]     <= {WIDTH{1'b0}};
        carry_r[i] <= 1'b0;
      end
    end else if (adv_s) begin
      flags_r <= flags_nxt_s;
      for (int i = 0; i < STAGES; i++) begin
        valid_r[i] <= vin_s[i];
        a_r[i]     <= a_in_s[i];
        b_r[i]     <= b_in_s[i];
        s_r[i]     <= s_nxt_s[i];
        carry_r[i] <= cout_s[i];
      end
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign s         = s_r[STAGES-1];
  assign cf        = flags_r[FLAG_CF];
  assign of        = flags_r[FLAG_OF];
  assign zf        = flags_r[FLAG_ZF];
  assign sf        = flags_r[FLAG_SF];
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=32, STAGES=4): latency, flags, streaming,
// stall behaviour and asynchronous reset with beats in flight.
module tb_pipelined_addsub;
  logic        clk, rst_n;
  logic        in_valid, in_ready, ci, sub, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        cf, of, zf, sf;
  int          n_vec = 0;
  int          n_bad = 0;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cf(cf), .of(of), .zf(zf), .sf(sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result check: out_valid, sum, and flags packed {sf,zf,of,cf}.
  task automatic chk_res(input string tag, input logic [31:0] es, input logic [3:0] ef);
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_s"}, {32'd0, s}, {32'd0, es});
    check({tag, "_flags"}, {60'd0, sf, zf, of, cf}, {60'd0, ef});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic sb);
    in_valid = 1'b1; a = av; b = bv; ci = c; sub = sb;
  endtask

  task automatic idle();
    in_valid = 1'b0; a = 32'd0; b = 32'd0; ci = 1'b0; sub = 1'b0;
  endtask

  function automatic logic [35:0] ref_res(input logic [31:0] av, input logic [31:0] bv,
                                          input logic c, input logic sb);
    logic [31:0] bb;
    logic [32:0] t;
    logic        ovf;
    bb  = sb ? ~bv : bv;
    t   = {1'b0, av} + {1'b0, bb} + {32'd0, c};
    ovf = ~(av[31] ^ bb[31]) & (av[31] ^ t[31]);
    return {t[31], (t[31:0] == 32'd0), ovf, t[32], t[31:0]};
  endfunction

  logic [35:0] expq[$];
  logic [35:0] e;
  int          nb, npop;
  logic [31:0] av, bv;

  initial begin
    rst_n = 1'b1; out_ready = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_s_flags", {28'd0, sf, zf, of, cf, s}, 64'd0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Signed overflow, exact 4-cycle latency
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    tick(); idle(); tick(); tick();
    check("t1_not_early", {63'd0, out_valid}, 64'd0);
    tick();
    chk_res("t1", 32'h8000_0000, 4'b1010);

    // Equal subtract then negative result
    drive(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1); tick();
    drive(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1); tick();
    idle(); tick(); tick();
    chk_res("t2a", 32'h0000_0000, 4'b0101);
    tick();
    chk_res("t2b", 32'hFFFF_FFFE, 4'b1000);

    // Carry rippling through every chunk, via b and via ci
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); tick();
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0); tick();
    idle(); tick(); tick();
    chk_res("t3a", 32'h0000_0000, 4'b0101);
    tick();
    chk_res("t3b", 32'h0000_0000, 4'b0101);
    tick(); tick();

    // Eight back-to-back beats, results on consecutive cycles
    for (int t = 0; t < 11; t++) begin
      if (t < 8) begin
        av = 32'(t);
        drive(av, av << 28, 1'b0, 1'b0);
      end else begin
        idle();
      end
      tick();
      if (t >= 3) begin
        av = 32'(t - 3);
        chk_res("t4", av | (av << 28), {1'b0, (av == 32'd0), 2'b00});
      end else begin
        check("t4_not_early", {63'd0, out_valid}, 64'd0);
      end
    end
    tick();
    check("t4_drained", {63'd0, out_valid}, 64'd0);

    // Stream with a 6-cycle downstream stall
    nb = 0; npop = 0;
    for (int c = 0; c < 40; c++) begin
      if (nb < 16) begin
        av = 32'h1000 + 32'(nb);
        bv = 32'h11 * 32'(nb);
        drive(av, bv, nb[0], nb[0]);
      end else begin
        idle();
      end
      out_ready = !(c >= 5 && c < 11);
      @(negedge clk);
      if (c == 10) begin
        check("t5_in_ready_full", {63'd0, in_ready}, 64'd0);
        check("t5_valid_held", {63'd0, out_valid}, 64'd1);
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("t5_spurious", {63'd0, out_valid}, 64'd0);
        end else begin
          e = expq[0];
          check("t5_s", {32'd0, s}, {32'd0, e[31:0]});
          check("t5_flags", {60'd0, sf, zf, of, cf}, {60'd0, e[35:32]});
          if (out_ready) begin
            void'(expq.pop_front());
            npop++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_res(a, b, ci, sub));
        nb++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("t5_all_out", {32'd0, 32'(npop)}, 64'd16);
    check("t5_queue_empty", {32'd0, 32'(expq.size())}, 64'd0);

    // Async reset with three beats in flight
    drive(32'h1, 32'h2, 1'b0, 1'b0); tick();
    drive(32'h3, 32'h4, 1'b0, 1'b0); tick();
    drive(32'h5, 32'h6, 1'b0, 1'b0); tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid_now", {63'd0, out_valid}, 64'd0);
    check("t6_flags_now", {60'd0, sf, zf, of, cf}, 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("t6_no_ghost", {63'd0, out_valid}, 64'd0);
    end
    check("t6_in_ready", {63'd0, in_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
